svc_rv_mem_model: RTL and testbench
===================================

SVC_RV_MEM_MODEL -- requirements
Module: svc_rv_mem_model

Interface
REQ-001 SHALL provide parameter WORDS, default 32, number of 32-bit words; power of two, 2..1024.
REQ-002 SHALL provide parameter LATENCY, default 1, read latency in cycles; legal 0..3.
REQ-003 SHALL provide parameter MAX_STALL, default 2, maximum consecutive stall cycles; legal 1..7.
REQ-004 SHALL provide parameter INIT_RDATA, default 32'h00000013, rdata value after reset.
REQ-005 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port stall_req, input, 1, stimulus-requested stall.
REQ-008 SHALL have port stall, output, 1, granted stall to the core.
REQ-009 SHALL have port ren, input, 1, read enable.
REQ-010 SHALL have port raddr, input, 32, byte read address.
REQ-011 SHALL have port rdata, output, 32, read data.
REQ-012 SHALL have port rvalid, output, 1, rdata holds the result of a ren.
REQ-013 SHALL have port we, input, 1, write enable.
REQ-014 SHALL have port waddr, input, 32, byte write address.
REQ-015 SHALL have port wdata, input, 32, write data.
REQ-016 SHALL have port wstrb, input, 4, byte-lane write strobes; bit n covers wdata[8n+7:8n].

Function
REQ-017 SHALL index words as addr[AW+1:2], AW=log2(WORDS); upper address bits ignored (wrap modulo WORDS); addr[1:0] ignored.
REQ-018 SHALL compute stall = stall_req && stall_cnt < MAX_STALL; stall_cnt increments each cycle stall is 1, clears on any cycle stall is 0.
REQ-019 SHALL therefore force stall=0 for at least one cycle after MAX_STALL consecutive stall cycles, even with stall_req held high.
REQ-020 SHALL, on a rising edge with we=1 and stall=0, write each lane whose wstrb bit is 1; lanes with wstrb=0 unchanged; we ignored while stall=1.
REQ-021 SHALL, for LATENCY=0, drive rdata = ren ? mem[idx] : 32'h0 combinationally, rvalid = ren; stall has no effect on rdata.
REQ-022 SHALL, for LATENCY>=1, implement LATENCY pipeline stages each holding {valid, data}; stages advance only on edges with stall=0.
REQ-023 SHALL load stage 0 with {1, mem[idx]} when ren=1 and {0, previous stage-0 data} when ren=0; rdata/rvalid driven from the last stage.
REQ-024 SHALL hold every stage (rdata and rvalid unchanged) on edges with stall=1.
REQ-025 SHALL give read-first semantics: read and write to the same word on one edge return pre-write data.
REQ-026 SHALL not alter memory contents on reset; memory SHALL initialise to all-zero at time zero.

Reset
REQ-027 SHALL, while reset=1 (asynchronously, including mid-stall or mid-read), force stall_cnt=0, stall=0, all stage valid bits 0, all stage data INIT_RDATA.
REQ-028 SHALL drive rdata=INIT_RDATA and rvalid=0 from reset assertion until the first ren reaches the last stage (LATENCY>=1).
REQ-029 SHALL discard in-flight reads on reset; no write SHALL occur on an edge where reset=1.

Configuration
REQ-030 SHALL compile stall logic only when macro SVC_RV_MEM_MODEL_STALL_EN is defined.
REQ-031 SHALL, with SVC_RV_MEM_MODEL_STALL_EN defined, behave per REQ-018..REQ-024.
REQ-032 SHALL, without SVC_RV_MEM_MODEL_STALL_EN, tie stall to 0, remove stall_cnt, ignore stall_req, and advance the pipeline every cycle.

Verification
REQ-033 SHALL cover: LATENCY=1, write 32'hDEADBEEF wstrb=4'hF to 0x10, then ren raddr=0x10 -> next cycle rdata=32'hDEADBEEF, rvalid=1.
REQ-034 SHALL cover: WORDS=32, write 32'h11223344 to 0x04, wstrb=4'b0010 write 32'h0000AA00 to 0x84 -> read 0x04 returns 32'h1122AA44 (wrap plus partial strobe).
REQ-035 SHALL cover: STALL_EN, MAX_STALL=2, stall_req high 5 cycles -> stall sequence 1,1,0,1,1; rdata unchanged during stall=1 cycles.
REQ-036 SHALL cover: LATENCY=3, ren to 0x00,0x04,0x08 on consecutive cycles holding 1,2,3 -> rdata 1,2,3 on cycles 3,4,5, each delayed one cycle per inserted stall.
REQ-037 SHALL cover: reset asserted between clocks with reads in flight -> immediately rdata=32'h00000013, rvalid=0, stall=0; memory word previously written retains its value.
REQ-038 SHALL cover: same-edge write 32'h5 and read at 0x20 holding 32'h7 -> rdata=32'h7, following read returns 32'h5.

Source files
------------

// File: rtl/svc_rv_mem_model.sv
// Word-addressed memory model for a RISC-V core: byte-strobed writes, 0..3 cycle read pipeline.
// Stall injection is compiled in only when SVC_RV_MEM_MODEL_STALL_EN is defined.
module svc_rv_mem_model #(
  parameter int          WORDS      = 32,
  parameter int          LATENCY    = 1,
  parameter int          MAX_STALL  = 2,
  parameter logic [31:0] INIT_RDATA = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_req,
  output logic        stall,
  input  logic        ren,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb
);

  localparam int AW = $clog2(WORDS);

  logic [AW-1:0] ridx;
  logic [AW-1:0] widx;
  logic [31:0]   mem [WORDS] = '{default: '0};

  // Addresses wrap modulo WORDS; the byte offset and upper bits are don't-care.
  assign ridx = raddr[AW+1:2];
  assign widx = waddr[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[31:AW+2], raddr[1:0], waddr[31:AW+2], waddr[1:0]};

`ifdef SVC_RV_MEM_MODEL_STALL_EN
  logic [2:0] stall_cnt;

  // Granted stall is capped so the core always sees a free cycle after MAX_STALL stalls.
  assign stall = !reset && stall_req && (stall_cnt < 3'(MAX_STALL));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 3'd1;
    else            stall_cnt <= '0;
  end
`else
  assign stall = 1'b0;

  logic unused_stall_req;
  assign unused_stall_req = stall_req;
`endif

  // NOTE: the memory array is deliberately not reset; it keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (we && !stall && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  if (LATENCY == 0) begin : g_comb
    // NOTE: outputs get defaults before any branch so no latch can be inferred.
    always_comb begin
      rdata  = '0;
      rvalid = ren;
      if (ren) rdata = mem[ridx];
    end
  end else begin : g_pipe
    logic [LATENCY-1:0] vld;
    logic [31:0]        dat [LATENCY];

    // Stage 0 samples the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld <= '0;
        for (int i = 0; i < LATENCY; i++) dat[i] <= INIT_RDATA;
      end else if (!stall) begin
        vld[0] <= ren;
        if (ren) dat[0] <= mem[ridx];
        for (int i = 1; i < LATENCY; i++) begin
          vld[i] <= vld[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end

    assign rdata  = dat[LATENCY-1];
    assign rvalid = vld[LATENCY-1];
  end

endmodule

// File: tb/tb_svc_rv_mem_model.sv
// Self-checking bench for svc_rv_mem_model: latency 0, 1 and 3 instances share one stimulus
// stream and are compared every cycle against a history-based reference model.
module tb_svc_rv_mem_model;

  localparam logic [31:0] INIT = 32'h00000013;
  localparam int          MS   = 2;

  typedef struct {
    bit          v;
    logic [31:0] d;
  } stage_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_req;
  logic        ren;
  logic [31:0] raddr;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        stall0, stall1, stall3;
  logic [31:0] rdata0, rdata1, rdata3;
  logic        rvalid0, rvalid1, rvalid3;

  int n_vec = 0;
  int n_mis = 0;

  // reference model state
  logic [31:0] mem_m [32];
  stage_t      hist [$];
  logic [31:0] last_d0;
  int          m_cnt;

  bit          exp_s [5];
  logic [31:0] exp_r [5];

  always #5 clock = ~clock;

  svc_rv_mem_model #(.WORDS(32), .LATENCY(0), .MAX_STALL(MS), .INIT_RDATA(INIT)) u_l0 (
    .clock(clock), .reset(reset), .stall_req(stall_req), .stall(stall0),
    .ren(ren), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb));

  svc_rv_mem_model #(.WORDS(32), .LATENCY(1), .MAX_STALL(MS), .INIT_RDATA(INIT)) u_l1 (
    .clock(clock), .reset(reset), .stall_req(stall_req), .stall(stall1),
    .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb));

  svc_rv_mem_model #(.WORDS(32), .LATENCY(3), .MAX_STALL(MS), .INIT_RDATA(INIT)) u_l3 (
    .clock(clock), .reset(reset), .stall_req(stall_req), .stall(stall3),
    .ren(ren), .raddr(raddr), .rdata(rdata3), .rvalid(rvalid3),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[6:2]);
  endfunction

  function automatic bit exp_stall();
`ifdef SVC_RV_MEM_MODEL_STALL_EN
    return !reset && stall_req && (m_cnt < MS);
`else
    return 1'b0;
`endif
  endfunction

  // Output of an L-stage pipe is the entry accepted L advancing edges ago.
  function automatic stage_t out_l(input int l);
    stage_t z;
    z.v = 1'b0;
    z.d = INIT;
    if (hist.size() >= l) return hist[l-1];
    return z;
  endfunction

  task automatic model_reset();
    hist.delete();
    last_d0 = INIT;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    bit     s;
    stage_t e;
    if (reset) return;
    s = exp_stall();
    if (!s) begin
      e.v = ren;
      e.d = ren ? mem_m[idx(raddr)] : last_d0;
      last_d0 = e.d;
      hist.push_front(e);
      if (hist.size() > 3) void'(hist.pop_back());
    end
    if (we && !s) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem_m[idx(waddr)][8*b +: 8] = wdata[8*b +: 8];
    end
    m_cnt = s ? m_cnt + 1 : 0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1'b1; waddr = a; wdata = d; wstrb = s; ren = 1'b0;
  endtask

  task automatic drive_rd(input logic [31:0] a);
    we = 1'b0; ren = 1'b1; raddr = a;
  endtask

  always @(negedge clock) begin : cmp
    bit          es;
    stage_t      e1;
    stage_t      e3;
    logic [31:0] e0;
    es = exp_stall();
    e1 = out_l(1);
    e3 = out_l(3);
    e0 = ren ? mem_m[idx(raddr)] : 32'h0;
    check("stall_l0",  {31'b0, stall0},  {31'b0, es});
    check("stall_l1",  {31'b0, stall1},  {31'b0, es});
    check("stall_l3",  {31'b0, stall3},  {31'b0, es});
    check("rdata_l0",  rdata0, e0);
    check("rvalid_l0", {31'b0, rvalid0}, {31'b0, ren});
    check("rdata_l1",  rdata1, e1.d);
    check("rvalid_l1", {31'b0, rvalid1}, {31'b0, e1.v});
    check("rdata_l3",  rdata3, e3.d);
    check("rvalid_l3", {31'b0, rvalid3}, {31'b0, e3.v});
  end

  initial begin
    exp_s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_r = '{32'h5, 32'h5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    reset = 1'b1; stall_req = 1'b0; ren = 1'b0; raddr = '0;
    we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    model_reset();

    repeat (2) tick();
    check("rst_rdata_l1",  rdata1, INIT);
    check("rst_rvalid_l1", {31'b0, rvalid1}, 32'h0);
    check("rst_rdata_l3",  rdata3, INIT);
    reset = 1'b0;

    // full-word write then read back
    drive_wr(32'h10, 32'hDEADBEEF, 4'hF);
    tick();
    drive_rd(32'h10);
    #1 check("l0_comb_read", rdata0, 32'hDEADBEEF);
    tick();
    check("rd_deadbeef", rdata1, 32'hDEADBEEF);
    check("rd_deadbeef_v", {31'b0, rvalid1}, 32'h1);

    // address wrap with a single-lane strobe
    drive_wr(32'h04, 32'h11223344, 4'hF);
    tick();
    drive_wr(32'h84, 32'h0000AA00, 4'b0010);
    tick();
    drive_rd(32'h04);
    tick();
    check("wrap_strobe", rdata1, 32'h1122AA44);

    // read-first on a same-edge read/write collision
    drive_wr(32'h20, 32'h7, 4'hF);
    tick();
    drive_wr(32'h20, 32'h5, 4'hF);
    ren = 1'b1; raddr = 32'h20;
    tick();
    check("read_first_old", rdata1, 32'h7);
    drive_rd(32'h20);
    tick();
    check("read_first_new", rdata1, 32'h5);

`ifdef SVC_RV_MEM_MODEL_STALL_EN
    // held stall request is broken up after MAX_STALL cycles; pipe frozen while stalled
    drive_rd(32'h10);
    stall_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 check("stall_seq", {31'b0, stall1}, {31'b0, exp_s[k]});
      tick();
      check("stall_hold", rdata1, exp_r[k]);
    end
    stall_req = 1'b0;
`endif

    // three back-to-back reads through the 3-deep pipe
    drive_wr(32'h00, 32'h1, 4'hF); tick();
    drive_wr(32'h04, 32'h2, 4'hF); tick();
    drive_wr(32'h08, 32'h3, 4'hF); tick();
    drive_rd(32'h00); tick();
    drive_rd(32'h04); tick();
    drive_rd(32'h08); tick();
    check("lat3_first", rdata3, 32'h1);
    ren = 1'b0;
    tick();
    check("lat3_second", rdata3, 32'h2);
    tick();
    check("lat3_third", rdata3, 32'h3);
    check("lat3_third_v", {31'b0, rvalid3}, 32'h1);

    // asynchronous reset with a read in flight; memory must survive, no write under reset
    drive_rd(32'h10);
    stall_req = 1'b1;
    tick();
    #2 reset = 1'b1;
    model_reset();
    drive_wr(32'h10, 32'hFFFFFFFF, 4'hF);
    #1;
    check("arst_rdata_l1",  rdata1, INIT);
    check("arst_rvalid_l1", {31'b0, rvalid1}, 32'h0);
    check("arst_rdata_l3",  rdata3, INIT);
    check("arst_stall",     {31'b0, stall1}, 32'h0);
    tick();
    reset = 1'b0;
    stall_req = 1'b0;
    drive_rd(32'h10);
    tick();
    check("mem_survives_rst", rdata1, 32'hDEADBEEF);

    // randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 600; c++) begin
      if (reset) reset = 1'b0;
      ren       = 1'($urandom_range(0, 1));
      raddr     = $urandom() & 32'hF00000FF;
      we        = 1'($urandom_range(0, 1));
      waddr     = $urandom() & 32'hF00000FF;
      wdata     = $urandom();
      wstrb     = 4'($urandom_range(0, 15));
      stall_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        #2 reset = 1'b1;
        model_reset();
      end
      tick();
    end

    reset = 1'b0;
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
